nn_stream_buffer: RTL and testbench

// Parametrised on-chip streaming buffer for the neural engine datapath: producer

---
 rtl/nn_stream_buffer_pkg.sv | 15 +
 rtl/nn_stream_buffer_if.sv | 28 ++
 rtl/nn_stream_buffer_sdp_ram.sv | 35 +++
 rtl/nn_stream_buffer.sv | 149 ++++++++++++++
 tb/tb_nn_stream_buffer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_stream_buffer_pkg.sv
// Shared definitions for the neural-engine on-chip memories.
//   NN_DATA_W / NN_DEPTH : default word width and entry count
//   nn_buf_state_e       : read-side FSM states of the stream buffer
package nn_stream_buffer_pkg;

  localparam int unsigned NN_DATA_W = 16;
  localparam int unsigned NN_DEPTH  = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } nn_buf_state_e;

endpackage

// File: rtl/nn_stream_buffer_if.sv
// Producer/consumer handshake bundle of the stream buffer.
//   wr_valid/wr_ready/wr_data : write side (producer -> buffer)
//   rd_valid/rd_ready/rd_data : read side (buffer -> consumer)
// Modports: master = the environment driving the buffer, slave = the buffer.
interface nn_stream_buffer_if
  import nn_stream_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = NN_DATA_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/nn_stream_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
//   clk, reset_n, clear : clock, async reset / sync clear of the output register only
//   we, waddr, wdata    : write port
//   re, raddr, rdata    : read port, rdata updates on the edge where re=1, else holds
// The array itself is never reset.
module nn_stream_buffer_sdp_ram
  import nn_stream_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = NN_DATA_W,
  parameter int unsigned DEPTH  = NN_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rdata <= '0;
    else if (clear) rdata <= '0;
    else if (re)    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nn_stream_buffer.sv
// Streaming FIFO buffer between loader/DMA and the MAC array.
//   clk, reset_n  : clock, async active-low reset
//   clear         : synchronous flush of pointers, FSM and flags
//   bus (slave)   : write and read valid/ready handshakes, rd_data registered
//   wait_cycles   : idle cycles inserted before each RAM fetch
//   level         : words held in RAM (the rd_data register is not counted)
//   full, empty   : level == DEPTH, level == 0
//   overflow      : sticky, a write was attempted while full
module nn_stream_buffer
  import nn_stream_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = NN_DATA_W,
  parameter int unsigned DEPTH  = NN_DEPTH,
  parameter int unsigned WAIT_W = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  nn_stream_buffer_if.slave      bus,
  input  logic [WAIT_W-1:0]      wait_cycles,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  nn_buf_state_e     state_q;
  logic [WAIT_W-1:0] cnt_q, wc_q;
  logic              rd_valid_q, overflow_q;
  logic              has_data, wr_en, fetch;
  logic [DATA_W-1:0] rd_data;

  assign full         = (level_q == FullLevel);
  assign empty        = (level_q == '0);
  assign has_data     = !empty;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign bus.wr_ready = !full;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data;
  assign wr_en        = bus.wr_valid && !full && !clear;

  // A fetch is the IDLE entry rule, also applied on the pop edge out of VALID.
  always_comb begin
    fetch = 1'b0;
    if (!clear) begin
      case (state_q)
        IDLE:    fetch = has_data && (wait_cycles == '0);
        WAIT:    fetch = (cnt_q == wc_q - WAIT_W'(1));
        VALID:   fetch = bus.rd_ready && has_data && (wait_cycles == '0);
        default: fetch = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fetch) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !fetch)      level_q <= level_q + LW'(1);
      else if (fetch && !wr_en) level_q <= level_q - LW'(1);
      if (bus.wr_valid && full) overflow_q <= 1'b1;
    end
  end

  // Read FSM; rd_valid is registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      wc_q       <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      wc_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch) begin
            state_q    <= VALID;
            rd_valid_q <= 1'b1;
          end else if (has_data) begin
            wc_q    <= wait_cycles;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (fetch) begin
            state_q    <= VALID;
            rd_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + WAIT_W'(1);
          end
        end
        VALID: begin
          if (bus.rd_ready && !fetch) begin
            rd_valid_q <= 1'b0;
            if (has_data) begin
              wc_q    <= wait_cycles;
              cnt_q   <= '0;
              state_q <= WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  nn_stream_buffer_sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .we     (wr_en),
    .waddr  (wr_ptr_q),
    .wdata  (bus.wr_data),
    .re     (fetch),
    .raddr  (rd_ptr_q),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_nn_stream_buffer.sv
module tb_nn_stream_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          reset_n, clear;
  logic [WW-1:0] wait_cycles;
  logic [3:0]    level;
  logic          full, empty, overflow;

  nn_stream_buffer_if #(.DATA_W(DW)) bus ();

  nn_stream_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_W(WW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .bus        (bus),
    .wait_cycles(wait_cycles),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: RAM contents as a queue, the output register as (m_valid, m_data),
  // and a countdown of idle cycles left before the next fetch (0 = no wait running).
  logic [DW-1:0] m_q[$];
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_ovf;
  int            m_wait_left;
  logic [DW-1:0] popped[$];

  function automatic void model_reset();
    m_q.delete();
    m_valid = 0;
    m_data = '0;
    m_ovf = 0;
    m_wait_left = 0;
  endfunction

  function automatic void model_step();
    bit fetch;
    bit was_full;
    if (clear) begin
      model_reset();
      return;
    end
    was_full = (m_q.size() == DEPTH);
    fetch = 0;
    if (m_valid && bus.rd_ready) m_valid = 0;
    if (!m_valid) begin
      if (m_wait_left > 0) begin
        m_wait_left--;
        fetch = (m_wait_left == 0);
      end else if (m_q.size() > 0) begin
        if (wait_cycles == 0) fetch = 1;
        else m_wait_left = int'(wait_cycles);
      end
    end
    if (fetch) begin
      m_data = m_q.pop_front();
      m_valid = 1;
    end
    if (bus.wr_valid) begin
      if (was_full) m_ovf = 1;
      else m_q.push_back(bus.wr_data);
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_data = 16'($urandom);
  endtask

  // Collect up to n popped words into popped[], bounded in cycles.
  task automatic drain(input int n);
    popped.delete();
    bus.rd_ready = 1'b1;
    for (int c = 0; c < n * 8 + 20 && popped.size() < n; c++) begin
      if (bus.rd_valid) popped.push_back(bus.rd_data);
      tick();
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); else passed++;
    checks++; if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
    checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags empty=%b full=%b want 1/0", empty, full); else passed++;
    checks++; if (bus.rd_data !== 16'h0) $display("FAIL reset_rd_data got %h want 0000", bus.rd_data); else passed++;
    checks++; if (bus.wr_ready !== 1'b1 || overflow !== 1'b0) $display("FAIL reset_ready_ovf wr_ready=%b ovf=%b want 1/0", bus.wr_ready, overflow); else passed++;
    // Mid-stream reset: none of these words may ever come out.
    wait_cycles = 2'd3;
    for (int i = 0; i < 3; i++) write_word(16'hC000 | 16'(i));
    do_reset();
    checks++; if (bus.rd_valid !== 1'b0 || level !== 4'd0 || empty !== 1'b1)
      $display("FAIL midreset_state rd_valid=%b level=%0d empty=%b want 0/0/1", bus.rd_valid, level, empty); else passed++;
    checks++; if (bus.rd_data !== 16'h0 || bus.wr_ready !== 1'b1)
      $display("FAIL midreset_data rd_data=%h wr_ready=%b want 0000/1", bus.rd_data, bus.wr_ready); else passed++;
    wait_cycles = 2'd0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.rd_valid !== 1'b0) $display("FAIL midreset_no_emerge cycle %0d got rd_valid=%b want 0", i, bus.rd_valid); else passed++;
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    wait_cycles = 2'd0;
    // With the consumer stalled one word sits in rd_data, so nine writes fill the RAM.
    for (int i = 1; i <= 9; i++) write_word(16'(i));
    checks++; if (full !== 1'b1 || bus.wr_ready !== 1'b0 || level !== 4'd8)
      $display("FAIL fill_full full=%b wr_ready=%b level=%0d want 1/0/8", full, bus.wr_ready, level); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL fill_no_ovf_yet got %b want 0", overflow); else passed++;
    write_word(16'hDEAD);
    checks++; if (overflow !== 1'b1 || level !== 4'd8) $display("FAIL ovf_set ovf=%b level=%0d want 1/8", overflow, level); else passed++;
    drain(9);
    checks++; if (popped.size() !== 9) $display("FAIL fill_pop_count got %0d want 9", popped.size()); else passed++;
    for (int i = 0; i < popped.size(); i++) begin
      checks++; if (popped[i] !== 16'(i + 1)) $display("FAIL fill_order idx %0d got %h want %h", i, popped[i], 16'(i + 1)); else passed++;
    end
    tick();
    checks++; if (overflow !== 1'b1 || empty !== 1'b1 || bus.rd_valid !== 1'b0)
      $display("FAIL fill_after ovf=%b empty=%b rd_valid=%b want 1/1/0", overflow, empty, bus.rd_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    wait_cycles = 2'(($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++) write_word(16'($urandom));
    drain(6);
    checks++; if (popped.size() !== 6) $display("FAIL wrap_first_count got %0d want 6", popped.size()); else passed++;
    for (int i = 0; i < 6; i++) write_word(16'hA000 + 16'(i));
    drain(6);
    checks++; if (popped.size() !== 6) $display("FAIL wrap_count got %0d want 6", popped.size()); else passed++;
    for (int i = 0; i < popped.size(); i++) begin
      checks++; if (popped[i] !== 16'hA000 + 16'(i)) $display("FAIL wrap_order idx %0d got %h want %h", i, popped[i], 16'hA000 + 16'(i)); else passed++;
    end
  endtask

  task automatic test_wait_states();
    int first_k;
    logic [DW-1:0] w[5];
    do_reset();
    wait_cycles = 2'd2;
    write_word(16'h1234);
    first_k = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (first_k == 0 && bus.rd_valid) first_k = k;
    end
    // Word present in RAM with the FSM idle: valid after 1 + wait_cycles edges.
    checks++; if (first_k !== 3) $display("FAIL wait_latency got %0d want 3", first_k); else passed++;
    checks++; if (bus.rd_data !== 16'h1234) $display("FAIL wait_data got %h want 1234", bus.rd_data); else passed++;
    drain(1);
    wait_cycles = 2'd0;
    for (int i = 0; i < 5; i++) begin
      w[i] = 16'($urandom);
      write_word(w[i]);
    end
    tick();
    checks++; if (level !== 4'd4 || bus.rd_valid !== 1'b1) $display("FAIL b2b_setup level=%0d rd_valid=%b want 4/1", level, bus.rd_valid); else passed++;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== w[i])
        $display("FAIL b2b_pop %0d rd_valid=%b data=%h want 1/%h", i, bus.rd_valid, bus.rd_data, w[i]); else passed++;
      tick();
    end
    checks++; if (bus.rd_valid !== 1'b0) $display("FAIL b2b_end rd_valid=%b want 0", bus.rd_valid); else passed++;
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[5];
    do_reset();
    wait_cycles = 2'd0;
    for (int i = 0; i < 5; i++) begin
      w[i] = 16'($urandom);
      write_word(w[i]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.rd_data !== w[0] || bus.rd_valid !== 1'b1 || level !== 4'd4)
        $display("FAIL stall_hold %0d data=%h valid=%b level=%0d want %h/1/4", i, bus.rd_data, bus.rd_valid, level, w[0]); else passed++;
    end
    bus.rd_ready = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data = 16'h5A5A;
    tick();
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b0;
    checks++; if (level !== 4'd4) $display("FAIL simul_level got %0d want 4", level); else passed++;
    checks++; if (bus.rd_data !== w[1]) $display("FAIL simul_data got %h want %h", bus.rd_data, w[1]); else passed++;
  endtask

  task automatic test_clear();
    do_reset();
    wait_cycles = 2'd0;
    for (int i = 0; i < 10; i++) write_word(16'h7000 + 16'(i));
    bus.rd_ready = 1'b1;
    repeat (3) tick();
    bus.rd_ready = 1'b0;
    checks++; if (level !== 4'd5 || overflow !== 1'b1 || bus.rd_valid !== 1'b1)
      $display("FAIL clear_setup level=%0d ovf=%b valid=%b want 5/1/1", level, overflow, bus.rd_valid); else passed++;
    clear = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data = 16'hBEEF;
    tick();
    clear = 1'b0;
    bus.wr_valid = 1'b0;
    checks++; if (level !== 4'd0 || bus.rd_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL clear_state level=%0d valid=%b ovf=%b want 0/0/0", level, bus.rd_valid, overflow); else passed++;
    checks++; if (bus.rd_data !== 16'h0 || empty !== 1'b1) $display("FAIL clear_data data=%h empty=%b want 0000/1", bus.rd_data, empty); else passed++;
    bus.rd_ready = 1'b1;
    repeat (4) tick();
    bus.rd_ready = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) $display("FAIL clear_discard rd_valid=%b want 0", bus.rd_valid); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.wr_valid = ($urandom_range(0, 99) < 55);
      bus.wr_data = 16'($urandom);
      bus.rd_ready = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 9) == 0) wait_cycles = 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 99) == 0);
      tick();
      checks++; if (bus.rd_valid !== m_valid) $display("FAIL rand_valid cyc %0d got %b want %b", c, bus.rd_valid, m_valid); else passed++;
      checks++; if (bus.rd_data !== m_data) $display("FAIL rand_data cyc %0d got %h want %h", c, bus.rd_data, m_data); else passed++;
      checks++; if (level !== 4'(m_q.size())) $display("FAIL rand_level cyc %0d got %0d want %0d", c, level, m_q.size()); else passed++;
      checks++; if (overflow !== m_ovf || full !== (m_q.size() == DEPTH))
        $display("FAIL rand_flags cyc %0d ovf=%b full=%b want %b/%b", c, overflow, full, m_ovf, m_q.size() == DEPTH); else passed++;
    end
    clear = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    wait_cycles = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_wait_states();
    test_backpressure();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
